occ_rom_arbiter: RTL and testbench
==================================

# occ_rom_arbiter

Round-robin arbiter that shares one Occ ROM read port between N_REQ accelerator cores (each an `accelerator_top_4`-class core exposing `ce_rom_Occ_o` / `addr_rom_Occ_o` / `data_Occ_i` / `data_Occ_valid_i`). It owns the single outstanding ROM transaction. It returns read data to the granted core with a one-cycle valid pulse and releases the requester if the ROM does not answer in time. It sits between the core array and the Occ ROM.

## Interface
- N_REQ, default 4, number of requesting cores (2..8).
- ADDR_W, default 8, Occ ROM address width.
- DATA_W, default 32, Occ ROM data width.
- TIMEOUT, default 64, maximum BUSY cycles waiting for ROM valid (≥2).

- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_ce_i  in  N_REQ  per-core read request (core's `ce_rom_Occ_o`).
- req_addr_i  in  N_REQ*ADDR_W  per-core address; core i occupies bits [i*ADDR_W +: ADDR_W].
- req_data_o  out  DATA_W  response data, broadcast to all cores.
- req_valid_o  out  N_REQ  one-hot response strobe; core i uses bit i as `data_Occ_valid_i`.
- ce_rom_Occ_o  out  1  ROM chip enable.
- addr_rom_Occ_o  out  ADDR_W  ROM address.
- data_Occ_i  in  DATA_W  ROM read data.
- data_Occ_valid_i  in  1  ROM data valid.
- grant_o  out  N_REQ  one-hot owner of the current transaction; 0 in IDLE.
- busy_o  out  1  high in BUSY and RESP.
- timeout_o  out  1  sticky; set on any timeout; cleared only by rst.

## Operation
- Requester rule: a core holds `req_ce_i[i]` and its address stable until it sees `req_valid_o[i]`. It may present a new request, or drop `ce`, in the cycle after the strobe.
- State machine: IDLE, BUSY, RESP.
- **IDLE → BUSY** when any `req_ce_i` is high.
  - Winner: the first asserted bit scanning upward from `rr_ptr`, wrapping N_REQ-1→0.
  - Registers winner into `grant_o`.
  - Registers that core's address into `addr_rom_Occ_o`.
  - Sets `ce_rom_Occ_o`=1 and clears the wait counter.
- **BUSY**
  - `ce_rom_Occ_o` stays 1 and the address is held.
  - When `data_Occ_valid_i`=1: capture `data_Occ_i` into `req_data_o`, go to RESP.
  - Otherwise the counter increments. When it reaches TIMEOUT-1 without valid: `req_data_o` ← 0, `timeout_o` ← 1, go to RESP.
- **RESP**
  - `ce_rom_Occ_o`=0 and `req_valid_o` = `grant_o` for exactly this cycle.
  - `rr_ptr` ← (winner+1) mod N_REQ.
  - Next state IDLE. `req_ce_i` is not sampled in RESP.
- **IDLE**: `grant_o`=0 and `req_valid_o`=0. `req_data_o` holds its last value.
- `data_Occ_valid_i` in IDLE or RESP is ignored (stray). It does not update `req_data_o`.
- If the granted core drops `ce` mid-BUSY, the transaction still completes and the strobe is still delivered.
- Requests from non-granted cores remain pending and do not disturb the transaction in flight.

## Timing
- Reset values:
  - state IDLE, `rr_ptr` 0.
  - `ce_rom_Occ_o`, `addr_rom_Occ_o`, `req_data_o`, `req_valid_o`, `grant_o`, `busy_o`, `timeout_o` all 0.
  - Wait counter 0.
- Reset mid-transaction: the next cycle is IDLE with all reset values. The in-flight ROM response is discarded.
- Request sampled at edge t:
  - `ce_rom_Occ_o` high in cycle t+1.
  - ROM valid in cycle t+k (k≥1) → `req_valid_o` high in cycle t+k+1.
  - Re-arbitration possible at edge t+k+2.
  - With a 1-cycle ROM, each core request takes 3 cycles from request to IDLE.
- Back-to-back requests from a single core: one transaction every 3 cycles with a 1-cycle ROM.
- Timeout: `ce_rom_Occ_o` is high for exactly TIMEOUT cycles, then RESP.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
- Single request, core 2, addr 0x5A, ROM valid one cycle after ce, data 0xDEADBEEF:
  - `addr_rom_Occ_o`=0x5A with `ce_rom_Occ_o` high for 1 cycle.
  - `req_valid_o`=4'b0100 for 1 cycle with `req_data_o`=0xDEADBEEF.
  - `grant_o`=4'b0100 during BUSY/RESP.
- All four cores request continuously from reset: grants in order 0,1,2,3,0. Each core gets its own address's data. No `req_valid_o` overlap.
- Cores 1 and 3 request with `rr_ptr`=2: core 3 is served first, then core 1. `rr_ptr` ends at 2.
- ROM never answers, TIMEOUT=64:
  - `ce_rom_Occ_o` is high 64 cycles.
  - Then `req_valid_o` pulses with `req_data_o`=0 and `timeout_o`=1 stays set.
  - The next request completes normally.
- Stray `data_Occ_valid_i` in IDLE with data 0x1234: `req_data_o` unchanged and no strobe.
- `rst` asserted in BUSY, then ROM valid arrives: no strobe, all outputs 0, and a new request is accepted normally after reset.

Source files
------------

// File: rtl/occ_rom_arbiter.sv
// Round-robin arbiter sharing one Occ ROM read port among N_REQ cores.
// Latency: request->ROM ce 1 cycle, ROM valid->strobe 1 cycle; requesters hold ce until their strobe.
module occ_rom_arbiter #(
  parameter int N_REQ   = 4,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_ce_i,
  input  logic [N_REQ*ADDR_W-1:0] req_addr_i,
  output logic [DATA_W-1:0]       req_data_o,
  output logic [N_REQ-1:0]        req_valid_o,
  output logic                    ce_rom_Occ_o,
  output logic [ADDR_W-1:0]       addr_rom_Occ_o,
  input  logic [DATA_W-1:0]       data_Occ_i,
  input  logic                    data_Occ_valid_i,
  output logic [N_REQ-1:0]        grant_o,
  output logic                    busy_o,
  output logic                    timeout_o
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_RESP
  } state_t;

  state_t              state_q, state_nxt;
  logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_nxt;
  logic [PTR_W-1:0]    win_q, win_nxt;
  logic [CNT_W-1:0]    cnt_q, cnt_nxt;
  logic [DATA_W-1:0]   data_q, data_nxt;
  logic [N_REQ-1:0]    valid_q, valid_nxt;
  logic [N_REQ-1:0]    grant_q, grant_nxt;
  logic                ce_q, ce_nxt;
  logic [ADDR_W-1:0]   addr_q, addr_nxt;
  logic                busy_q, busy_nxt;
  logic                tmo_q, tmo_nxt;

  logic                win_found;
  logic [PTR_W-1:0]    win_idx;
  logic [ADDR_W-1:0]   sel_addr;

  // Scan upward from rr_ptr with wrap; the sum needs one extra bit before folding.
  always_comb begin
    logic [PTR_W:0] idx_w;
    win_found = 1'b0;
    win_idx   = '0;
    idx_w     = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx_w = {1'b0, rr_ptr_q} + (PTR_W+1)'(i);
      if (idx_w >= (PTR_W+1)'(N_REQ)) begin
        idx_w = idx_w - (PTR_W+1)'(N_REQ);
      end
      if (!win_found && req_ce_i[idx_w[PTR_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = idx_w[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    sel_addr = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_idx == PTR_W'(i)) begin
        sel_addr = req_addr_i[i*ADDR_W +: ADDR_W];
      end
    end
  end

  always_comb begin
    state_nxt  = state_q;
    rr_ptr_nxt = rr_ptr_q;
    win_nxt    = win_q;
    cnt_nxt    = cnt_q;
    data_nxt   = data_q;
    valid_nxt  = '0;
    grant_nxt  = grant_q;
    ce_nxt     = ce_q;
    addr_nxt   = addr_q;
    busy_nxt   = busy_q;
    tmo_nxt    = tmo_q;

    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          state_nxt = ST_BUSY;
          win_nxt   = win_idx;
          grant_nxt = N_REQ'(1) << win_idx;
          addr_nxt  = sel_addr;
          ce_nxt    = 1'b1;
          cnt_nxt   = '0;
          busy_nxt  = 1'b1;
        end
      end

      ST_BUSY: begin
        if (data_Occ_valid_i) begin
          data_nxt  = data_Occ_i;
          state_nxt = ST_RESP;
          ce_nxt    = 1'b0;
          valid_nxt = grant_q;
        end else if (cnt_q == CNT_W'(TIMEOUT-1)) begin
          // Release the requester with zero data so it cannot stall forever.
          data_nxt  = '0;
          tmo_nxt   = 1'b1;
          state_nxt = ST_RESP;
          ce_nxt    = 1'b0;
          valid_nxt = grant_q;
        end else begin
          cnt_nxt = cnt_q + CNT_W'(1);
        end
      end

      ST_RESP: begin
        state_nxt  = ST_IDLE;
        grant_nxt  = '0;
        busy_nxt   = 1'b0;
        rr_ptr_nxt = (win_q == PTR_W'(N_REQ-1)) ? '0 : win_q + PTR_W'(1);
      end

      default: begin
        state_nxt = ST_IDLE;
        grant_nxt = '0;
        ce_nxt    = 1'b0;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      win_q    <= '0;
      cnt_q    <= '0;
      data_q   <= '0;
      valid_q  <= '0;
      grant_q  <= '0;
      ce_q     <= 1'b0;
      addr_q   <= '0;
      busy_q   <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_nxt;
      rr_ptr_q <= rr_ptr_nxt;
      win_q    <= win_nxt;
      cnt_q    <= cnt_nxt;
      data_q   <= data_nxt;
      valid_q  <= valid_nxt;
      grant_q  <= grant_nxt;
      ce_q     <= ce_nxt;
      addr_q   <= addr_nxt;
      busy_q   <= busy_nxt;
      tmo_q    <= tmo_nxt;
    end
  end

  assign req_data_o     = data_q;
  assign req_valid_o    = valid_q;
  assign grant_o        = grant_q;
  assign ce_rom_Occ_o   = ce_q;
  assign addr_rom_Occ_o = addr_q;
  assign busy_o         = busy_q;
  assign timeout_o      = tmo_q;

endmodule

// File: tb/tb_occ_rom_arbiter.sv
// Scoreboarded random bench for occ_rom_arbiter with a list-scheduling reference model.
module tb_occ_rom_arbiter;
  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int TO = 64;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req_ce;
  logic [N*AW-1:0] req_addr;
  logic [DW-1:0]   req_data_o;
  logic [N-1:0]    req_valid_o;
  logic            ce_rom_Occ_o;
  logic [AW-1:0]   addr_rom_Occ_o;
  logic [DW-1:0]   data_Occ_i;
  logic            data_Occ_valid_i;
  logic [N-1:0]    grant_o;
  logic            busy_o;
  logic            timeout_o;

  occ_rom_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk              (clk),
    .rst              (rst),
    .req_ce_i         (req_ce),
    .req_addr_i       (req_addr),
    .req_data_o       (req_data_o),
    .req_valid_o      (req_valid_o),
    .ce_rom_Occ_o     (ce_rom_Occ_o),
    .addr_rom_Occ_o   (addr_rom_Occ_o),
    .data_Occ_i       (data_Occ_i),
    .data_Occ_valid_i (data_Occ_valid_i),
    .grant_o          (grant_o),
    .busy_o           (busy_o),
    .timeout_o        (timeout_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int            core;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            ce_cycles;
    logic          tmo;
  } exp_t;

  exp_t          sb[$];
  logic [AW-1:0] addr_q [N][$];
  logic [DW-1:0] rom_mem [256];

  int            vectors = 0;
  int            miscompares = 0;
  int            m_ptr = 0;
  logic          m_tmo = 1'b0;
  logic [DW-1:0] m_last = '0;
  logic          early_drop = 1'b0;

  int            rom_lat = 1;
  int            rom_cnt = 0;
  logic          rom_vld = 1'b0;
  logic [DW-1:0] rom_dat = '0;
  logic          stray_vld = 1'b0;
  logic [DW-1:0] stray_dat = '0;

  assign data_Occ_valid_i = rom_vld | stray_vld;
  assign data_Occ_i       = stray_vld ? stray_dat : rom_dat;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ROM: answers rom_lat cycles into a ce burst (1 = same cycle as first ce); 0 never answers.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (ce_rom_Occ_o) begin
        rom_cnt++;
        if (rom_lat != 0 && rom_cnt == rom_lat) begin
          rom_vld = 1'b1;
          rom_dat = rom_mem[addr_rom_Occ_o];
        end else begin
          rom_vld = 1'b0;
        end
      end else begin
        rom_cnt = 0;
        rom_vld = 1'b0;
      end
    end
  end

  // Monitor: counts ce cycles per transaction and checks each strobe against the scoreboard.
  initial begin
    int            ce_cnt;
    logic [AW-1:0] cap_addr;
    exp_t          e;
    ce_cnt   = 0;
    cap_addr = '0;
    forever begin
      @(posedge clk);
      #2;
      if (rst) begin
        ce_cnt = 0;
      end else begin
        if (ce_rom_Occ_o) begin
          if (ce_cnt == 0) cap_addr = addr_rom_Occ_o;
          ce_cnt++;
        end
        if (req_valid_o != '0) begin
          chk("strobe_expected", DW'(sb.size() != 0), DW'(1));
          if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("valid_vec", DW'(req_valid_o), DW'(1 << e.core));
            chk("grant_vec", DW'(grant_o), DW'(1 << e.core));
            chk("resp_data", req_data_o, e.data);
            chk("rom_addr", DW'(cap_addr), DW'(e.addr));
            chk("ce_cycles", DW'(ce_cnt), DW'(e.ce_cycles));
            chk("timeout_flag", DW'(timeout_o), DW'(e.tmo));
            chk("busy_in_resp", DW'(busy_o), DW'(1));
          end
          ce_cnt = 0;
        end
      end
    end
  end

  // Core behaviour: hold ce/addr until own strobe, then present the next queued address.
  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (req_valid_o[i] && addr_q[i].size() != 0) begin
        addr_q[i].delete(0);
        if (addr_q[i].size() != 0) begin
          req_ce[i]             = 1'b1;
          req_addr[i*AW +: AW] = addr_q[i][0];
        end else begin
          req_ce[i] = 1'b0;
        end
      end else if (early_drop && grant_o[i] && busy_o) begin
        req_ce[i] = 1'b0;
      end
    end
  endtask

  // Reference: every core with work left is pending at each arbitration, so service
  // order is the next pending core cyclically after the previous winner.
  task automatic start_phase(input int lat);
    int   rem[N];
    int   k[N];
    int   w;
    exp_t e;
    rom_lat = lat;
    for (int i = 0; i < N; i++) begin
      rem[i] = addr_q[i].size();
      k[i]   = 0;
    end
    while (1) begin
      w = -1;
      for (int j = 0; j < N; j++) begin
        if (w < 0 && rem[(m_ptr + j) % N] > 0) w = (m_ptr + j) % N;
      end
      if (w < 0) break;
      e.core      = w;
      e.addr      = addr_q[w][k[w]];
      e.data      = (lat == 0) ? '0 : rom_mem[e.addr];
      e.ce_cycles = (lat == 0) ? TO : lat;
      if (lat == 0) m_tmo = 1'b1;
      e.tmo       = m_tmo;
      sb.push_back(e);
      m_last = e.data;
      rem[w]--;
      k[w]++;
      m_ptr = (w + 1) % N;
    end
    for (int i = 0; i < N; i++) begin
      if (addr_q[i].size() != 0) begin
        req_ce[i]             = 1'b1;
        req_addr[i*AW +: AW] = addr_q[i][0];
      end
    end
  endtask

  function automatic logic pending();
    logic p;
    p = busy_o || (sb.size() != 0);
    for (int i = 0; i < N; i++) p = p || (addr_q[i].size() != 0);
    return p;
  endfunction

  task automatic wait_done(input string nm);
    int n;
    n = 0;
    while (pending() && n < 3000) begin
      tick();
      n++;
    end
    vectors++;
    if (pending()) begin
      miscompares++;
      $display("FAIL %s: phase not drained after %0d cycles, %0d responses outstanding", nm, n, sb.size());
      sb.delete();
      for (int i = 0; i < N; i++) addr_q[i].delete();
      req_ce = '0;
    end
    tick();
  endtask

  task automatic check_zero(input string nm);
    chk({nm, "_ce"},    DW'(ce_rom_Occ_o),   '0);
    chk({nm, "_addr"},  DW'(addr_rom_Occ_o), '0);
    chk({nm, "_data"},  req_data_o,          '0);
    chk({nm, "_valid"}, DW'(req_valid_o),    '0);
    chk({nm, "_grant"}, DW'(grant_o),        '0);
    chk({nm, "_busy"},  DW'(busy_o),         '0);
    chk({nm, "_tmo"},   DW'(timeout_o),      '0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_ce = '0;
    for (int i = 0; i < N; i++) addr_q[i].delete();
    tick();
    tick();
    rst = 1'b0;
    m_ptr  = 0;
    m_tmo  = 1'b0;
    m_last = '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst      = 1'b1;
    req_ce   = '0;
    req_addr = '0;
    for (int a = 0; a < 256; a++) rom_mem[a] = $urandom;
    rom_mem[8'h5A] = 32'hDEADBEEF;
    tick();
    tick();
    tick();
    rst = 1'b0;
    check_zero("reset");

    // Single request: core 2, addr 0x5A, 1-cycle ROM
    addr_q[2].push_back(8'h5A);
    start_phase(1);
    wait_done("single_core2");

    // All four cores continuously from reset: 0,1,2,3,0
    do_reset();
    for (int i = 0; i < N; i++) addr_q[i].push_back(AW'($urandom));
    addr_q[0].push_back(AW'($urandom));
    start_phase(1);
    wait_done("all_four");

    // Move rr_ptr to 2, then cores 1 and 3 together: 3 first, then 1
    addr_q[1].push_back(AW'($urandom));
    start_phase(1);
    wait_done("ptr_to_2");
    addr_q[1].push_back(AW'($urandom));
    addr_q[3].push_back(AW'($urandom));
    start_phase(2);
    wait_done("cores_1_3");

    // ROM never answers, then a normal request with timeout_o still set
    addr_q[0].push_back(AW'($urandom));
    start_phase(0);
    wait_done("timeout");
    addr_q[1].push_back(AW'($urandom));
    start_phase(1);
    wait_done("after_timeout");

    // Stray ROM valid in IDLE
    stray_dat = 32'h1234;
    stray_vld = 1'b1;
    tick();
    stray_vld = 1'b0;
    chk("stray_data",  req_data_o, m_last);
    chk("stray_valid", DW'(req_valid_o), '0);
    tick();
    chk("stray_data2", req_data_o, m_last);
    chk("stray_grant", DW'(grant_o), '0);

    // Granted core drops ce mid-BUSY: strobe still delivered
    early_drop = 1'b1;
    addr_q[3].push_back(AW'($urandom));
    addr_q[0].push_back(AW'($urandom));
    start_phase(3);
    wait_done("early_drop");
    early_drop = 1'b0;

    // Reset in BUSY, late ROM valid afterwards is ignored
    rom_lat  = 3;
    req_ce[2] = 1'b1;
    req_addr[2*AW +: AW] = 8'h33;
    n = 0;
    while (!ce_rom_Occ_o && n < 20) begin
      tick();
      n++;
    end
    chk("mid_reset_busy_seen", DW'(ce_rom_Occ_o), DW'(1));
    tick();
    rst    = 1'b1;
    req_ce = '0;
    tick();
    rst       = 1'b0;
    stray_dat = 32'hCAFE0000;
    stray_vld = 1'b1;
    tick();
    stray_vld = 1'b0;
    check_zero("mid_reset");
    m_ptr  = 0;
    m_tmo  = 1'b0;
    m_last = '0;
    addr_q[2].push_back(8'h33);
    start_phase(1);
    wait_done("after_mid_reset");

    // Randomized phases
    for (int p = 0; p < 40; p++) begin
      int tot;
      tot = 0;
      for (int i = 0; i < N; i++) begin
        int c;
        c = $urandom_range(0, 3);
        for (int j = 0; j < c; j++) addr_q[i].push_back(AW'($urandom));
        tot += c;
      end
      if (tot == 0) addr_q[$urandom_range(0, N-1)].push_back(AW'($urandom));
      early_drop = ($urandom_range(0, 3) == 0);
      start_phase($urandom_range(1, 4));
      wait_done("random_phase");
      early_drop = 1'b0;
    end

    tick();
    tick();
    chk("scoreboard_empty", DW'(sb.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
